rc4_encrypt: RTL
================

Name: rc4_encrypt

Overview:
- Encrypt-side counterpart of the key-cracking datapath.
- Takes a 24-bit key and a length-prefixed plaintext memory, then runs RC4 in three phases: S-box init, KSA, PRGA.
- Writes a length-prefixed ciphertext memory in the exact format the crack/doublecrack cores consume.
- Used to generate ct_mem images in-system and for round-trip self-test.

Parameters:
- KEYLEN, 3, key length in bytes; key byte n = key[8*(KEYLEN-1-n) +: 8], so byte 0 is the MSB.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  high when idle and able to accept en
- key  input  24  RC4 key; latched on the en&rdy cycle
- pt_addr  output  8  plaintext memory read address
- pt_rddata  input  8  plaintext read data
- ct_addr  output  8  ciphertext memory write address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write enable
- s_addr  output  8  S-box memory address (single port)
- s_wrdata  output  8  S-box write data
- s_wren  output  1  S-box write enable
- s_rddata  input  8  S-box read data

Behaviour:
- Reset: synchronous, active-low; clock clk.
  - rst_n=0 forces IDLE from any state, including mid-operation.
  - Outputs in reset and IDLE: rdy=1; ct_wren=0; s_wren=0; all addresses and wrdata 0.
  - Internal i, j, k, len registers clear to 0.
- Memories: pt, ct and S are synchronous RAMs. Data for the address presented in cycle t is valid in cycle t+1; the FSM inserts one wait state per read.
- Handshake:
  - en&rdy latches key and leaves IDLE; rdy drops the next cycle.
  - en while rdy=0 is ignored.
  - rdy rises when the FSM returns to IDLE after the last ct write.
  - Completion = rdy rising edge.
- INIT: 256 cycles; S[i]=i for i=0..255 (s_wren=1, s_addr=i, s_wrdata=i).
- KSA, for i=0..255:
  - read S[i];
  - j = (j + S[i] + keybyte[i mod KEYLEN]) mod 256;
  - read S[j];
  - write S[i]=old S[j], then S[j]=old S[i].
  - i=j must still leave S unchanged.
- LEN:
  - read pt[0] into len;
  - write ct[0]=len unencrypted.
  - len=0 skips PRGA and goes to IDLE.
- PRGA: i=j=0 at entry; for k=1..len:
  - i=(i+1) mod 256; read S[i];
  - j=(j+S[i]) mod 256; read S[j];
  - swap S[i] and S[j] (two writes);
  - read S[(S[i]+S[j]) mod 256] using post-swap values = pad;
  - read pt[k];
  - write ct[k]=pt[k] xor pad.
- Arithmetic: all S and j arithmetic is modulo 256 (8-bit wrap). k is a 9-bit counter so len=255 terminates after k=255 with no wrap to 0.
- Write discipline:
  - ct_wren is high for exactly len+1 single-cycle pulses per run, at addresses 0..len in ascending order.
  - No two S writes occur in the same cycle.
- Key stability: a key change after the latch has no effect on the current run.

Test Plan:
- key=0x4B6579 ("Key"), pt = 09 'P' 'l' 'a' 'i' 'n' 't' 'e' 'x' 't' -> ct[0..9] = 09 BB F3 16 E8 D9 40 AF 0A D3. Exactly 10 ct_wren pulses, then rdy=1.
- pt[0]=00, any key -> single write ct[0]=00 and return to IDLE; S holds the post-KSA permutation (checked against model).
- pt[0]=FF, random key and data -> 256 ct writes matching the reference model; no write to address 0 after ct[0]; FSM terminates.
- Round trip: encrypt with key 0x1E4600, reload ct as pt, encrypt again with the same key -> output equals the original plaintext byte-for-byte.
- Assert rst_n=0 for 1 cycle mid-KSA (i=100) -> next cycle rdy=1, ct_wren=0, s_wren=0. A fresh en run then matches the first vector exactly.
- en held high continuously, and key changed during a run -> exactly one run per rdy window; ciphertext reflects the key latched at start.

Source files
------------

// File: rtl/rc4_encrypt_if.sv
// Bundle of handshake, key and memory-port signals for the RC4 encrypt core.
// The slave modport is the core's view; master is the host/memory side.
interface rc4_encrypt_if #(
    parameter int KEYLEN = 3
);
    logic                  en;
    logic                  rdy;
    logic [8*KEYLEN-1:0]   key;
    logic [7:0]            pt_addr;
    logic [7:0]            pt_rddata;
    logic [7:0]            ct_addr;
    logic [7:0]            ct_wrdata;
    logic                  ct_wren;
    logic [7:0]            s_addr;
    logic [7:0]            s_wrdata;
    logic                  s_wren;
    logic [7:0]            s_rddata;

    modport slave (
        input  en, key, pt_rddata, s_rddata,
        output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );

    modport master (
        output en, key, pt_rddata, s_rddata,
        input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/rc4_encrypt.sv
// RC4 encryptor: S-box init, KSA, then PRGA over a length-prefixed plaintext,
// writing a length-prefixed ciphertext image. All memories are 1-cycle sync RAMs.
module rc4_encrypt #(
    parameter int KEYLEN = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    rc4_encrypt_if.slave  bus
);
    localparam int KW = 8 * KEYLEN;

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        K_RDI, K_GETI, K_RDJ, K_GETJ, K_WRI, K_WRJ,
        L_RD, L_GET, L_WR,
        P_RDI, P_GETI, P_RDJ, P_GETJ, P_WRI, P_WRJ, P_RDP, P_XOR
    } state_t;

    state_t        state, state_nx, cur;
    logic [7:0]    i, j, len, si, sj;
    logic [8:0]    k;
    logic [KW-1:0] key_r, key_rot;
    logic [7:0]    key_byte;

    // Key bytes are consumed MSB-first by rotating the latched key one byte
    // per KSA step, which yields keybyte[i mod KEYLEN] without a divider.
    assign key_byte = key_r[KW-1 -: 8];
    generate
        if (KEYLEN > 1) begin : g_rot
            assign key_rot = {key_r[KW-9:0], key_r[KW-1 -: 8]};
        end else begin : g_norot
            assign key_rot = key_r;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
            key_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        key_r <= bus.key;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                INIT:   i <= i + 8'd1;
                K_GETI: begin
                    si    <= bus.s_rddata;
                    j     <= j + bus.s_rddata + key_byte;
                    key_r <= key_rot;
                end
                K_GETJ: sj <= bus.s_rddata;
                K_WRJ:  i  <= i + 8'd1;
                L_GET:  len <= bus.pt_rddata;
                L_WR: begin
                    i <= '0;
                    j <= '0;
                    k <= 9'd1;
                end
                P_RDI:  i <= i + 8'd1;
                P_GETI: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata;
                end
                P_GETJ: sj <= bus.s_rddata;
                P_XOR:  k  <= k + 9'd1;
                default: ;
            endcase
        end
    end

    // Outputs fall back to idle values combinationally while reset is asserted.
    always_comb begin
        cur           = rst_n ? state : IDLE;
        state_nx      = cur;
        bus.rdy       = 1'b0;
        bus.pt_addr   = '0;
        bus.ct_addr   = '0;
        bus.ct_wrdata = '0;
        bus.ct_wren   = 1'b0;
        bus.s_addr    = '0;
        bus.s_wrdata  = '0;
        bus.s_wren    = 1'b0;
        case (cur)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) state_nx = INIT;
            end
            INIT: begin
                bus.s_wren   = 1'b1;
                bus.s_addr   = i;
                bus.s_wrdata = i;
                if (i == 8'hFF) state_nx = K_RDI;
            end
            K_RDI: begin
                bus.s_addr = i;
                state_nx   = K_GETI;
            end
            K_GETI: state_nx = K_RDJ;
            K_RDJ: begin
                bus.s_addr = j;
                state_nx   = K_GETJ;
            end
            K_GETJ: state_nx = K_WRI;
            K_WRI: begin
                bus.s_wren   = 1'b1;
                bus.s_addr   = i;
                bus.s_wrdata = sj;
                state_nx     = K_WRJ;
            end
            K_WRJ: begin
                bus.s_wren   = 1'b1;
                bus.s_addr   = j;
                bus.s_wrdata = si;
                state_nx     = (i == 8'hFF) ? L_RD : K_RDI;
            end
            L_RD: begin
                bus.pt_addr = 8'd0;
                state_nx    = L_GET;
            end
            L_GET: state_nx = L_WR;
            L_WR: begin
                bus.ct_wren   = 1'b1;
                bus.ct_addr   = 8'd0;
                bus.ct_wrdata = len;
                state_nx      = (len == 8'd0) ? IDLE : P_RDI;
            end
            P_RDI: begin
                bus.s_addr = i + 8'd1;
                state_nx   = P_GETI;
            end
            P_GETI: state_nx = P_RDJ;
            P_RDJ: begin
                bus.s_addr = j;
                state_nx   = P_GETJ;
            end
            P_GETJ: state_nx = P_WRI;
            P_WRI: begin
                bus.s_wren   = 1'b1;
                bus.s_addr   = i;
                bus.s_wrdata = sj;
                state_nx     = P_WRJ;
            end
            P_WRJ: begin
                bus.s_wren   = 1'b1;
                bus.s_addr   = j;
                bus.s_wrdata = si;
                state_nx     = P_RDP;
            end
            P_RDP: begin
                // Post-swap S[i]+S[j] is sj+si, so the pad index needs no re-read.
                bus.s_addr  = si + sj;
                bus.pt_addr = k[7:0];
                state_nx    = P_XOR;
            end
            P_XOR: begin
                bus.ct_wren   = 1'b1;
                bus.ct_addr   = k[7:0];
                bus.ct_wrdata = bus.pt_rddata ^ bus.s_rddata;
                state_nx      = (k == {1'b0, len}) ? IDLE : P_RDI;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
